// File: rtl/dsp_logic_pipe.sv
// dsp_logic_pipe: elastic pipeline that applies a bitwise logic operation
// to operands a and b. The result is formed in stage 0 and carried
// unchanged through STAGES register stages, with a valid/ready handshake
// on both sides. Define DSP_LOGIC_PATDET_EN to add the registered 'zero'
// flag (result is all-zero) that travels alongside the result.
module dsp_logic_pipe #(
  parameter int WIDTH  = 48,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef DSP_LOGIC_PATDET_EN
  ,
  output logic             zero
`endif
);

  // Parameter legality is checked while the design is elaborated.
  if (WIDTH < 1 || WIDTH > 48) begin : g_bad_width
    $error("dsp_logic_pipe: parameter WIDTH=%0d is outside the legal range 1..48", WIDTH);
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("dsp_logic_pipe: parameter STAGES=%0d is outside the legal range 1..4", STAGES);
  end

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_XNOR  = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_ANDN  = 3'd6,
    OP_ORN   = 3'd7
  } op_e;

  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] advance;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  result;
  logic              accept;

`ifdef DSP_LOGIC_PATDET_EN
  logic              zero_q [STAGES];
`endif

  // Stage-0 combinational logic unit.
  always_comb begin
    // NOTE: every path assigns result (default first), so no latch is inferred.
    result = '0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_ANDN: result = a & ~b;
      OP_ORN:  result = a | ~b;
      default: result = '0;
    endcase
  end

  // Ready chain, walked from the output back to the input: a stage may
  // load when it is empty or when its own contents move on this cycle.
  always_comb begin
    advance = '0;
    load    = '0;
    advance[STAGES-1] = out_ready;
    load[STAGES-1]    = !valid_q[STAGES-1] || advance[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      advance[k] = load[k+1];
      load[k]    = !valid_q[k] || advance[k];
    end
  end

  // Handshake outputs; both read 0 while reset is held low.
  assign in_ready  = reset && load[0];
  assign accept    = in_valid && in_ready;
  assign out_valid = reset && valid_q[STAGES-1];
  assign y         = data_q[STAGES-1];

  // Pipeline registers: valid bits follow the load enables, data only
  // moves when a real beat moves so an empty stage keeps its old value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the data stages are reset too, because y must read 0 after reset.
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
      if (load[0]) begin
        valid_q[0] <= accept;
        if (accept) data_q[0] <= result;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) data_q[k] <= data_q[k-1];
        end
      end
    end
  end

`ifdef DSP_LOGIC_PATDET_EN
  // All-zero flag, formed in stage 0 and shifted with the result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) begin
        zero_q[k] <= 1'b0;
      end
    end else begin
      if (load[0] && accept) zero_q[0] <= (result == '0);
      for (int k = 1; k < STAGES; k++) begin
        if (load[k] && valid_q[k-1]) zero_q[k] <= zero_q[k-1];
      end
    end
  end

  assign zero = zero_q[STAGES-1];
`endif

endmodule

// File: doc/dsp_logic_pipe.md
DSP_LOGIC_PIPE -- requirements
Module: dsp_logic_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, giving the operand and result width; legal range 1..48.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the pipeline depth in register stages; legal range 1..4.
REQ-003 Out-of-range WIDTH or STAGES SHALL raise an elaboration-time error naming the parameter and its value.
REQ-004 Port clock SHALL be a 1-bit input: the single clock, rising-edge active.
REQ-005 Port reset SHALL be a 1-bit input: reset, synchronous and active-low.
REQ-006 Port in_valid SHALL be a 1-bit input: the upstream beat is valid.
REQ-007 Port in_ready SHALL be a 1-bit output: the block accepts a beat this cycle.
REQ-008 Port op SHALL be a 3-bit input: the operation select, sampled with a and b.
REQ-009 Ports a and b SHALL be WIDTH-bit inputs: the operands.
REQ-010 Port out_valid SHALL be a 1-bit output: y is valid.
REQ-011 Port out_ready SHALL be a 1-bit input: downstream accepts y.
REQ-012 Port y SHALL be a WIDTH-bit output: the result.
REQ-013 Port zero SHALL be a 1-bit output that exists only when DSP_LOGIC_PATDET_EN is defined: y is all-zero.

Function
REQ-014 Op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 a&~b, 7 a|~b; the operation is bitwise over WIDTH bits.
REQ-015 A beat SHALL be accepted on a rising edge where in_valid && in_ready; a, b and op are captured together.
REQ-016 The pipeline SHALL be elastic with STAGES stages, each holding a valid bit plus data.
REQ-017 Stage k SHALL load from stage k-1 when stage k is empty or stage k itself advances that cycle.
REQ-018 The last stage SHALL advance when out_ready is high.
REQ-019 in_ready SHALL equal !valid[0] || advance[0]; the ready chain is combinational from out_ready.
REQ-020 Without backpressure, latency SHALL be exactly STAGES cycles from acceptance to out_valid, at a throughput of 1 beat per cycle.
REQ-021 The result SHALL be computed in stage 0; later stages carry the result unchanged.
REQ-022 While out_valid && !out_ready, y, zero and out_valid SHALL hold stable.
REQ-023 No beat SHALL be dropped, duplicated or reordered under any in_valid/out_ready pattern.
REQ-024 When all stages are full and out_ready is low, in_ready SHALL be 0.
REQ-025 Simultaneous acceptance and emission when full SHALL be allowed (out_ready=1 -> in_ready=1 in the same cycle).
REQ-026 in_ready SHALL not depend on in_valid.

Reset
REQ-027 While reset=0 at a rising edge, all stage valid bits, y and zero SHALL clear to 0.
REQ-028 While reset=0, in_ready SHALL be forced to 0 and out_valid SHALL read 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats with no output emitted.
REQ-030 The first cycle after reset deasserts SHALL have in_ready=1.

Configuration
REQ-031 Macro DSP_LOGIC_PATDET_EN defined: port zero SHALL be present, registered alongside the result in stage 0, and equal to (y == 0) whenever out_valid=1.
REQ-032 Macro DSP_LOGIC_PATDET_EN undefined: port zero and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 WIDTH=8, STAGES=2, out_ready=1, beats op=0..7 with a=8'hF0, b=8'hCC on consecutive cycles -> y = C0, FC, 3C, C3, 3F, 03, 30, F3 respectively, each exactly 2 cycles after acceptance, one per cycle.
REQ-034 WIDTH=8, STAGES=3, continuous in_valid, out_ready=0 for 6 cycles -> in_ready falls after 3 accepts, y holds the first result; on out_ready=1 the 3 results drain in order, then streaming resumes at full rate.
REQ-035 Random in_valid/out_ready (50% each), 1000 beats, WIDTH=48 -> output sequence matches a reference model exactly, with no loss or duplication.
REQ-036 Pipeline full with reset pulsed low for 1 cycle -> out_valid=0 thereafter, and none of the pre-reset beats appears at the output.
REQ-037 With DSP_LOGIC_PATDET_EN defined, op=2 (XOR), a=b=8'h5A -> y=8'h00, zero=1; a=8'h5A, b=8'h5B -> y=8'h01, zero=0.
REQ-038 WIDTH=1, STAGES=1, op=3 (XNOR), a=0, b=0 -> y=1 one cycle after acceptance.
